// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, bypass and
// BIST status registers, and control strobes for an external boundary-scan chain.
module tap_ctrl #(
  parameter int unsigned IR_W = 3
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  input  logic            bsr_scan_out,
  output logic            bsr_shift,
  output logic            bsr_clk_dr,
  output logic            bsr_update,
  output logic            bsr_sel,
  output logic            bist_run,
  input  logic            bist_done,
  output logic [3:0]      state,
  output logic [IR_W-1:0] ir
);

  typedef enum logic [3:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SEL_DR  = 4'h7,
    CAP_DR  = 4'h6,
    SH_DR   = 4'h2,
    EX1_DR  = 4'h1,
    PAUSE_DR= 4'h3,
    EX2_DR  = 4'h0,
    UPD_DR  = 4'h5,
    SEL_IR  = 4'h4,
    CAP_IR  = 4'hE,
    SH_IR   = 4'hA,
    EX1_IR  = 4'h9,
    PAUSE_IR= 4'hB,
    EX2_IR  = 4'h8,
    UPD_IR  = 4'hD
  } tap_state_e;

  localparam logic [IR_W-1:0] IR_EXTEST  = '0;
  localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(1);
  localparam logic [IR_W-1:0] IR_RUNBIST = IR_W'(2);
  localparam logic [IR_W-1:0] IR_BYPASS  = '1;

  tap_state_e      r_state;
  tap_state_e      w_next;
  logic [IR_W-1:0] r_ir_sr;
  logic [IR_W-1:0] r_ir;
  logic            r_bypass;
  logic            r_status;

  logic            w_sel_bsr;
  logic            w_sel_status;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      TLR:      w_next = tms ? TLR    : RTI;
      RTI:      w_next = tms ? SEL_DR : RTI;
      SEL_DR:   w_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:   w_next = tms ? EX1_DR : SH_DR;
      SH_DR:    w_next = tms ? EX1_DR : SH_DR;
      EX1_DR:   w_next = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: w_next = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   w_next = tms ? UPD_DR : SH_DR;
      UPD_DR:   w_next = tms ? SEL_DR : RTI;
      SEL_IR:   w_next = tms ? TLR    : CAP_IR;
      CAP_IR:   w_next = tms ? EX1_IR : SH_IR;
      SH_IR:    w_next = tms ? EX1_IR : SH_IR;
      EX1_IR:   w_next = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: w_next = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   w_next = tms ? UPD_IR : SH_IR;
      UPD_IR:   w_next = tms ? SEL_DR : RTI;
      default:  w_next = TLR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) r_state <= TLR;
    else     r_state <= w_next;
  end

  // Capture/shift act on the edge that leaves Cap/Sh; pause states fall through.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_ir_sr <= '0;
    end else if (r_state == CAP_IR) begin
      r_ir_sr <= IR_W'(1);
    end else if (r_state == SH_IR) begin
      r_ir_sr <= {tdi, r_ir_sr[IR_W-1:1]};
    end
  end

  // Entering TLR is detected from the next state so ir is BYPASS in the TLR cycle itself.
  always_ff @(posedge clock) begin
    if (rst || (w_next == TLR)) begin
      r_ir <= IR_BYPASS;
    end else if (r_state == UPD_IR) begin
      r_ir <= r_ir_sr;
    end
  end

  always_comb begin
    w_sel_bsr    = (r_ir == IR_EXTEST) || (r_ir == IR_SAMPLE);
    w_sel_status = (r_ir == IR_RUNBIST);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_bypass <= 1'b0;
      r_status <= 1'b0;
    end else if (r_state == CAP_DR) begin
      if (w_sel_status) r_status <= bist_done;
      else if (!w_sel_bsr) r_bypass <= 1'b0;
    end else if (r_state == SH_DR) begin
      if (w_sel_status) r_status <= tdi;
      else if (!w_sel_bsr) r_bypass <= tdi;
    end
  end

  always_comb begin
    tdo        = 1'b0;
    tdo_en     = 1'b0;
    bsr_shift  = 1'b0;
    bsr_clk_dr = 1'b0;
    bsr_update = 1'b0;
    bsr_sel    = (r_ir == IR_EXTEST);
    bist_run   = w_sel_status && (r_state == RTI);
    if (r_state == SH_IR) begin
      tdo    = r_ir_sr[0];
      tdo_en = 1'b1;
    end else if (r_state == SH_DR) begin
      tdo_en = 1'b1;
      if (w_sel_bsr)         tdo = bsr_scan_out;
      else if (w_sel_status) tdo = r_status;
      else                   tdo = r_bypass;
    end
    if (w_sel_bsr) begin
      bsr_clk_dr = (r_state == CAP_DR) || (r_state == SH_DR);
      bsr_shift  = (r_state == SH_DR);
      bsr_update = (r_state == UPD_DR);
    end
  end

  assign state = r_state;
  assign ir    = r_ir;

endmodule

// File: doc/tap_ctrl.md
TAP_CTRL -- requirements
Module: tap_ctrl

Interface
REQ-001 Parameter IR_W, default 3: instruction register width in bits, minimum 2.
REQ-002 clock  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 tms  input  1  test mode select; sampled every rising edge of clock.
REQ-005 tdi  input  1  test data in; also drives the boundary chain serial input.
REQ-006 tdo  output  1  test data out; serial LSB of the selected register.
REQ-007 tdo_en  output  1  high only in Shift-DR or Shift-IR.
REQ-008 bsr_scan_out  input  1  serial output of the last boundary-scan cell.
REQ-009 bsr_shift  output  1  shift/scan-in select for boundary cells.
REQ-010 bsr_clk_dr  output  1  boundary-cell capture/shift enable.
REQ-011 bsr_update  output  1  one-cycle boundary update strobe.
REQ-012 bsr_sel  output  1  selects boundary-register data onto core pins (EXTEST).
REQ-013 bist_run  output  1  BIST enable to BILBO control.
REQ-014 bist_done  input  1  BIST completion flag.
REQ-015 state  output  4  current TAP state encoding.
REQ-016 ir  output  IR_W  current (updated) instruction.

Function
REQ-017 The 16-state IEEE 1149.1 TAP FSM is implemented with this 4-bit encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
REQ-018 Transitions follow 1149.1 on tms each edge: TLR(1:TLR,0:RTI); RTI(1:SelDR,0:RTI); SelDR(1:SelIR,0:CapDR); SelIR(1:TLR,0:CapIR); Cap(1:Ex1,0:Sh); Sh(1:Ex1,0:Sh); Ex1(1:Upd,0:Pause); Pause(1:Ex2,0:Pause); Ex2(1:Upd,0:Sh); Upd(1:SelDR,0:RTI).
REQ-019 Five consecutive tms=1 cycles reach TLR from any state.
REQ-020 Instructions: EXTEST=0, SAMPLE=1, RUNBIST=2, BYPASS=all ones; any other code behaves as BYPASS.
REQ-021 IR shift register: CapIR loads ...001 (LSB=1, rest 0); ShIR shifts right, tdi into MSB; ir loads from shift register on the UpdIR edge only.
REQ-022 Entering TLR (by tms or rst) sets ir to BYPASS.
REQ-023 Bypass register, 1 bit: CapDR loads 0; ShDR loads tdi.
REQ-024 Status register, 1 bit, selected by RUNBIST: CapDR loads bist_done; ShDR loads tdi.
REQ-025 Boundary register selected by EXTEST or SAMPLE; external to this block.
REQ-026 tdo is combinational: ShIR -> IR shift LSB; ShDR -> bsr_scan_out, bypass bit or status bit per selected register; otherwise 0.
REQ-027 bsr_clk_dr = 1 when boundary selected and state is CapDR or ShDR.
REQ-028 bsr_shift = 1 when boundary selected and state is ShDR; 0 in CapDR (parallel capture).
REQ-029 bsr_update = 1 for exactly the one cycle in UpdDR with boundary selected.
REQ-030 bsr_sel = 1 whenever ir is EXTEST, independent of state; changes only at UpdIR or TLR entry.
REQ-031 bist_run = 1 while ir is RUNBIST and state is RTI; drops the cycle state leaves RTI.
REQ-032 All control outputs decode from registered state/ir; no tms-to-output combinational path.
REQ-033 Pause states hold all shift registers unchanged.

Reset
REQ-034 rst high at a rising edge: state=TLR(F), ir=BYPASS, IR shift=0, bypass=0, status=0; rst has priority over tms.
REQ-035 During and after reset: tdo=0, tdo_en=0, bsr_shift=0, bsr_clk_dr=0, bsr_update=0, bsr_sel=0, bist_run=0.
REQ-036 rst mid-shift discards partial IR/DR contents; ir is not updated.

Verification
REQ-037 From RTI drive tms=1 x5 -> state=F each step ends in F, ir=111.
REQ-038 Load IR=000 via SelDR,SelIR,CapIR,ShIR x3 (tdi 0,0,0, tms=1 on last),Ex1IR,UpdIR -> tdo shifts 1,0,0; ir=000 and bsr_sel=1 after UpdIR.
REQ-039 BYPASS, ShDR with tdi pattern 1,0,1,1 -> tdo 0,1,0,1 (one-cycle delay, leading captured 0).
REQ-040 EXTEST, CapDR->ShDR x4->Ex1DR->UpdDR -> bsr_clk_dr high 5 cycles, bsr_shift high 4, bsr_update high exactly 1 cycle.
REQ-041 RUNBIST then RTI 10 cycles with bist_done raised -> bist_run high 10 cycles; next DR scan shifts out 1 first.
REQ-042 rst asserted in ShIR after 2 bits -> state=F, ir=111, all strobes 0 next cycle.
